// File: rtl/tff_toggle_arbiter_if.sv
// Client-side bus of the toggle-flip-flop bank: toggle requests, bank load,
// grant pulses and the registered bank state/counter.
interface tff_toggle_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NTFF = 8,
  parameter int unsigned IDXW = $clog2(NTFF),
  parameter int unsigned CNTW = 16
);
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] idx;
  logic                 load;
  logic [NTFF-1:0]      load_val;
  logic [NREQ-1:0]      gnt;
  logic [NTFF-1:0]      tff_out;
  logic [CNTW-1:0]      tog_cnt;

  modport master (
    output req, idx, load, load_val,
    input  gnt, tff_out, tog_cnt
  );

  modport slave (
    input  req, idx, load, load_val,
    output gnt, tff_out, tog_cnt
  );
endinterface

// File: rtl/tff_toggle_arbiter.sv
// Bank of toggle flip-flops shared by NREQ requesters through a round-robin
// arbiter; one toggle per cycle, with a whole-bank load path and a toggle counter.
module tff_toggle_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NTFF = 8,
  parameter int unsigned IDXW = $clog2(NTFF),
  parameter int unsigned CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  tff_toggle_arbiter_if.slave    bus
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NTFF-1:0] tff_q, tff_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [PTRW-1:0] win;
  logic [IDXW-1:0] win_idx;
  logic            in_range;

  // Round-robin pick: first eligible at/after the pointer, else wrap to the lowest.
  // A requester granted last cycle is masked so a held req cannot double-toggle.
  always_comb begin : arbitrate
    elig    = bus.req & ~gnt_q;
    found   = 1'b0;
    win     = '0;
    win_idx = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (!found && elig[r] && (PTRW'(r) >= ptr_q)) begin
        found   = 1'b1;
        win     = PTRW'(r);
        win_idx = bus.idx[r*IDXW +: IDXW];
      end
    end
    for (int r = 0; r < int'(NREQ); r++) begin
      if (!found && elig[r]) begin
        found   = 1'b1;
        win     = PTRW'(r);
        win_idx = bus.idx[r*IDXW +: IDXW];
      end
    end
    in_range = (32'(win_idx) < NTFF);
  end

  // Load wins over arbitration; an out-of-range target is granted but has no effect.
  always_comb begin : next_state
    ptr_d = ptr_q;
    gnt_d = '0;
    tff_d = tff_q;
    cnt_d = cnt_q;
    if (bus.load) begin
      tff_d = bus.load_val;
    end else if (found) begin
      gnt_d = NREQ'(1) << win;
      ptr_d = (win == PTRW'(NREQ - 1)) ? '0 : win + PTRW'(1);
      if (in_range) begin
        tff_d = tff_q ^ (NTFF'(1) << win_idx);
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      ptr_q <= '0;
      gnt_q <= '0;
      tff_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      tff_q <= tff_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.tff_out = tff_q;
  assign bus.tog_cnt = cnt_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Bench for tff_toggle_arbiter: an 8-bit bank and a 6-bit bank (for out-of-range
// indices) driven by the same requesters, checked against a behavioural model.
module tb_tff_toggle_arbiter;

  typedef struct {
    int         ptr;
    logic [7:0] tff;
    logic [3:0] gnt;
    int         cnt;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] idx;
  logic        load;
  logic [7:0]  load_val;

  int n_cmp = 0;
  int n_err = 0;
  mstate_t ma, mb;

  tff_toggle_arbiter_if #(.NREQ(4), .NTFF(8)) bus_a ();
  tff_toggle_arbiter_if #(.NREQ(4), .NTFF(6)) bus_b ();

  assign bus_a.req      = req;
  assign bus_a.idx      = idx;
  assign bus_a.load     = load;
  assign bus_a.load_val = load_val;
  assign bus_b.req      = req;
  assign bus_b.idx      = idx;
  assign bus_b.load     = load;
  assign bus_b.load_val = load_val[5:0];

  tff_toggle_arbiter #(.NREQ(4), .NTFF(8), .IDXW(3), .CNTW(16)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  tff_toggle_arbiter #(.NREQ(4), .NTFF(6), .IDXW(3), .CNTW(16)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // One clock edge of the bank as described by its rules.
  function automatic mstate_t model_step(mstate_t s, int ntff, bit r, bit [3:0] rq,
                                         bit [11:0] ix, bit ld, bit [7:0] lv);
    mstate_t n;
    bit [3:0] e;
    bit [11:0] ixv;
    int w, t;
    n = s;
    if (r) begin
      n.ptr = 0; n.tff = '0; n.gnt = '0; n.cnt = 0;
      return n;
    end
    n.gnt = '0;
    if (ld) begin
      n.tff = lv;
      for (int b = ntff; b < 8; b++) n.tff[b] = 1'b0;
      return n;
    end
    e = rq & ~s.gnt;
    if (e == 4'b0) return n;
    w = s.ptr;
    for (int k = 0; k < 4; k++) begin
      w = (s.ptr + k) % 4;
      if (e[w]) break;
    end
    n.gnt[w] = 1'b1;
    n.ptr = (w + 1) % 4;
    ixv = ix;
    t = int'(ixv[w*3 +: 3]);
    if (t < ntff) begin
      n.tff[t] = ~n.tff[t];
      n.cnt = (s.cnt + 1) % 65536;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = model_step(ma, 8, rst, req, idx, load, load_val);
    mb = model_step(mb, 6, rst, req, idx, load, load_val);
    #1;
  endtask

  task automatic set_idx(int r, int v);
    idx[r*3 +: 3] = 3'(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req = 4'($urandom); idx = 12'($urandom); load = 1'($urandom); load_val = 8'($urandom);
      tick();
      n_cmp++;
      if (bus_a.tff_out !== 8'h00 || bus_a.gnt !== 4'b0 || bus_a.tog_cnt !== 16'h0) begin
        n_err++;
        $display("FAIL reset_a: tff=%h gnt=%b cnt=%h, expected 00/0000/0000",
                 bus_a.tff_out, bus_a.gnt, bus_a.tog_cnt);
      end
      n_cmp++;
      if (bus_b.tff_out !== 6'h00 || bus_b.gnt !== 4'b0 || bus_b.tog_cnt !== 16'h0) begin
        n_err++;
        $display("FAIL reset_b: tff=%h gnt=%b cnt=%h, expected 00/0000/0000",
                 bus_b.tff_out, bus_b.gnt, bus_b.tog_cnt);
      end
    end
    rst = 1'b0; req = '0; load = 1'b0;
    tick();
    n_cmp++;
    if (bus_a.tff_out !== 8'h00 || bus_a.gnt !== 4'b0 || bus_a.tog_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL post_reset: tff=%h gnt=%b cnt=%h, expected 00/0000/0000",
               bus_a.tff_out, bus_a.gnt, bus_a.tog_cnt);
    end
  endtask

  task automatic test_single_toggle();
    req = 4'b0100; set_idx(2, 5);
    tick();
    n_cmp++;
    if (bus_a.gnt !== 4'b0100 || bus_a.tff_out !== 8'h20 || bus_a.tog_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL single_1: gnt=%b tff=%h cnt=%0d, expected 0100/20/1",
               bus_a.gnt, bus_a.tff_out, bus_a.tog_cnt);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (bus_a.gnt !== 4'b0000 || bus_a.tff_out !== 8'h20) begin
      n_err++;
      $display("FAIL single_gap: gnt=%b tff=%h, expected 0000/20", bus_a.gnt, bus_a.tff_out);
    end
    req = 4'b0100;
    tick();
    n_cmp++;
    if (bus_a.gnt !== 4'b0100 || bus_a.tff_out !== 8'h00 || bus_a.tog_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL single_2: gnt=%b tff=%h cnt=%0d, expected 0100/00/2",
               bus_a.gnt, bus_a.tff_out, bus_a.tog_cnt);
    end
    n_cmp++;
    if (bus_b.tff_out !== mb.tff[5:0] || bus_b.tog_cnt !== 16'(mb.cnt)) begin
      n_err++;
      $display("FAIL single_b: tff=%h cnt=%0d, expected %h/%0d",
               bus_b.tff_out, bus_b.tog_cnt, mb.tff[5:0], mb.cnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int r = 0; r < 4; r++) set_idx(r, r);
    for (int g = 0; g < 8; g++) begin
      tick();
      n_cmp++;
      if (bus_a.gnt !== 4'(1 << (g % 4))) begin
        n_err++;
        $display("FAIL rr_order[%0d]: gnt=%b, expected %b", g, bus_a.gnt, 4'(1 << (g % 4)));
      end
      if (g == 3 || g == 7) begin
        n_cmp++;
        if (bus_a.tff_out !== ((g == 3) ? 8'h0F : 8'h00) || bus_a.tog_cnt !== 16'(g + 1)) begin
          n_err++;
          $display("FAIL rr_state[%0d]: tff=%h cnt=%0d, expected %h/%0d", g,
                   bus_a.tff_out, bus_a.tog_cnt, (g == 3) ? 8'h0F : 8'h00, g + 1);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 8'hA5; req = 4'b0010; set_idx(1, 0);
    tick();
    n_cmp++;
    if (bus_a.tff_out !== 8'hA5 || bus_a.gnt !== 4'b0000 || bus_a.tog_cnt !== 16'(ma.cnt)) begin
      n_err++;
      $display("FAIL load_cycle: tff=%h gnt=%b cnt=%0d, expected A5/0000/%0d",
               bus_a.tff_out, bus_a.gnt, bus_a.tog_cnt, ma.cnt);
    end
    load = 1'b0;
    tick();
    n_cmp++;
    if (bus_a.tff_out !== 8'hA4 || bus_a.gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL load_after: tff=%h gnt=%b, expected A4/0010", bus_a.tff_out, bus_a.gnt);
    end
    n_cmp++;
    if (bus_b.tff_out !== 6'h24) begin
      n_err++;
      $display("FAIL load_b: tff=%h, expected 24", bus_b.tff_out);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [5:0] tff_b_before;
    int cnt_b_before;
    tff_b_before = mb.tff[5:0];
    cnt_b_before = mb.cnt;
    req = 4'b0001; set_idx(0, 7);
    tick();
    n_cmp++;
    if (bus_b.gnt !== 4'b0001 || bus_b.tff_out !== tff_b_before ||
        bus_b.tog_cnt !== 16'(cnt_b_before)) begin
      n_err++;
      $display("FAIL oor_b: gnt=%b tff=%h cnt=%0d, expected 0001/%h/%0d",
               bus_b.gnt, bus_b.tff_out, bus_b.tog_cnt, tff_b_before, cnt_b_before);
    end
    n_cmp++;
    if (bus_a.gnt !== 4'b0001 || bus_a.tff_out !== ma.tff || bus_a.tog_cnt !== 16'(ma.cnt)) begin
      n_err++;
      $display("FAIL oor_a: gnt=%b tff=%h cnt=%0d, expected 0001/%h/%0d",
               bus_a.gnt, bus_a.tff_out, bus_a.tog_cnt, ma.tff, ma.cnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int r = 0; r < 4; r++) set_idx(r, r);
    repeat (65535) tick();
    n_cmp++;
    if (bus_a.tog_cnt !== 16'hFFFF || bus_b.tog_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_full: cnt_a=%h cnt_b=%h, expected FFFF", bus_a.tog_cnt, bus_b.tog_cnt);
    end
    tick();
    n_cmp++;
    if (bus_a.tog_cnt !== 16'h0000 || bus_b.tog_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_zero: cnt_a=%h cnt_b=%h, expected 0000", bus_a.tog_cnt, bus_b.tog_cnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1011;
    for (int r = 0; r < 4; r++) set_idx(r, r);
    tick();
    tick();
    n_cmp++;
    if (bus_a.gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_setup: gnt=%b, expected 0010", bus_a.gnt);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus_a.tff_out !== 8'h00 || bus_a.gnt !== 4'b0 || bus_a.tog_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset: tff=%h gnt=%b cnt=%h, expected 00/0000/0000",
               bus_a.tff_out, bus_a.gnt, bus_a.tog_cnt);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus_a.gnt !== 4'b0001 || bus_a.tff_out !== 8'h01 || bus_a.tog_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL mid_first: gnt=%b tff=%h cnt=%0d, expected 0001/01/1",
               bus_a.gnt, bus_a.tff_out, bus_a.tog_cnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(63) == 0);
      load = ($urandom_range(7) == 0);
      load_val = 8'($urandom);
      for (int r = 0; r < 4; r++) begin
        if (req[r]) begin
          if ((ma.gnt[r] || rst) && $urandom_range(1) == 0) req[r] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req[r] = 1'b1;
          set_idx(r, int'($urandom_range(7)));
        end
      end
      tick();
      n_cmp++;
      if (bus_a.gnt !== ma.gnt) begin
        n_err++;
        $display("FAIL rand_gnt_a[%0d]: got %b, expected %b", c, bus_a.gnt, ma.gnt);
      end
      n_cmp++;
      if (bus_a.tff_out !== ma.tff) begin
        n_err++;
        $display("FAIL rand_tff_a[%0d]: got %h, expected %h", c, bus_a.tff_out, ma.tff);
      end
      n_cmp++;
      if (bus_a.tog_cnt !== 16'(ma.cnt)) begin
        n_err++;
        $display("FAIL rand_cnt_a[%0d]: got %0d, expected %0d", c, bus_a.tog_cnt, ma.cnt);
      end
      n_cmp++;
      if (bus_b.gnt !== mb.gnt) begin
        n_err++;
        $display("FAIL rand_gnt_b[%0d]: got %b, expected %b", c, bus_b.gnt, mb.gnt);
      end
      n_cmp++;
      if (bus_b.tff_out !== mb.tff[5:0]) begin
        n_err++;
        $display("FAIL rand_tff_b[%0d]: got %h, expected %h", c, bus_b.tff_out, mb.tff[5:0]);
      end
      n_cmp++;
      if (bus_b.tog_cnt !== 16'(mb.cnt)) begin
        n_err++;
        $display("FAIL rand_cnt_b[%0d]: got %0d, expected %0d", c, bus_b.tog_cnt, mb.cnt);
      end
    end
    rst = 1'b0; load = 1'b0; req = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; idx = '0; load = 1'b0; load_val = '0;
    ma = '{ptr: 0, tff: '0, gnt: '0, cnt: 0};
    mb = '{ptr: 0, tff: '0, gnt: '0, cnt: 0};
    test_reset();
    test_single_toggle();
    test_round_robin();
    test_load_priority();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
